// File: rtl/hv_encoder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hv_encoder_pkg : source codes, ALU op codes and source-width helper
// Rev 1.0
// ---------------------------------------------------------------------------
package hv_encoder_pkg;

    localparam int SRC_IM_A  = 0;
    localparam int SRC_IM_B  = 1;
    localparam int SRC_REG_A = 2;
    localparam int SRC_REG_B = 3;
    localparam int SRC_ALU   = 4;
    localparam int SRC_BUND0 = 5;

    localparam int ALU_XOR = 0;
    localparam int ALU_AND = 1;
    localparam int ALU_OR  = 2;
    localparam int ALU_ROT = 3;

    function automatic int src_width(input int num_bundlers);
        return $clog2(SRC_BUND0 + num_bundlers);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bundler_set.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bundler_set : per-bit saturating up/down counters, majority (count > 0) out
// Rev 1.0
// ---------------------------------------------------------------------------
module bundler_set #(
    parameter int WIDTH = 512,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] hv_i,
    output logic [WIDTH-1:0] hv_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    logic [CNT_W-1:0] cnt_q [WIDTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else if (en_i) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (hv_i[i] && (cnt_q[i] != CNT_MAX)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end else if (!hv_i[i] && (cnt_q[i] != CNT_MIN)) begin
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    // Ties (count zero) resolve to 0.
    for (genvar i = 0; i < WIDTH; i++) begin : g_out
        assign hv_o[i] = !cnt_q[i][CNT_W-1] && (cnt_q[i] != '0);
    end

endmodule
`default_nettype wire

// File: rtl/hv_enc_src_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hv_enc_src_mux : NUM_SRC-to-1 hypervector mux, out-of-range select -> zero
// Rev 1.0
// ---------------------------------------------------------------------------
module hv_enc_src_mux #(
    parameter int NUM_SRC = 9,
    parameter int WIDTH   = 512,
    parameter int SEL_W   = 4
) (
    input  logic [NUM_SRC*WIDTH-1:0] srcs_i,
    input  logic [SEL_W-1:0]         sel_i,
    output logic [WIDTH-1:0]         data_o
);

    always_comb begin
        data_o = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel_i == SEL_W'(i)) begin
                data_o = srcs_i[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_file_1w2r.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_file_1w2r : one-write two-read HV register file with synchronous clear
// Rev 1.0
// ---------------------------------------------------------------------------
module reg_file_1w2r #(
    parameter int  WIDTH    = 512,
    parameter int  NUM_REGS = 8,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_a_i,
    input  logic [AW-1:0]    rd_addr_b_i,
    output logic [WIDTH-1:0] rd_data_a_o,
    output logic [WIDTH-1:0] rd_data_b_o
);

    logic [WIDTH-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wr_en_i) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Reads see the pre-write contents, so read-during-write returns old data.
    assign rd_data_a_o = regs_q[rd_addr_a_i];
    assign rd_data_b_o = regs_q[rd_addr_b_i];

endmodule
`default_nettype wire

// File: rtl/hv_encoder_mc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hv_encoder_mc : instruction-driven multi-bundler HV encoder with qhv buffer
// Rev 1.0
// ---------------------------------------------------------------------------
module hv_encoder_mc
    import hv_encoder_pkg::*;
#(
    parameter int  HVDimension    = 512,
    parameter int  NumBundlers    = 4,
    parameter int  BundCountWidth = 8,
    parameter int  RegNum         = 8,
    parameter int  NumALUOps      = 4,
    parameter int  ALUMaxShiftAmt = 128,
    localparam int ALUOpsWidth    = $clog2(NumALUOps),
    localparam int ShiftWidth     = $clog2(ALUMaxShiftAmt),
    localparam int NumSrc         = SRC_BUND0 + NumBundlers,
    localparam int SrcWidth       = src_width(NumBundlers),
    localparam int RegAddrWidth   = $clog2(RegNum)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [HVDimension-1:0]        im_rd_a_i,
    input  logic [HVDimension-1:0]        im_rd_b_i,
    input  logic                          instr_valid_i,
    output logic                          instr_ready_o,
    input  logic [SrcWidth-1:0]           alu_src_a_i,
    input  logic [SrcWidth-1:0]           alu_src_b_i,
    input  logic [ALUOpsWidth-1:0]        alu_op_i,
    input  logic [ShiftWidth-1:0]         alu_shift_amt_i,
    input  logic [NumBundlers*SrcWidth-1:0] bund_src_i,
    input  logic [NumBundlers-1:0]        bund_valid_i,
    input  logic [NumBundlers-1:0]        bund_clr_i,
    input  logic [RegAddrWidth-1:0]       reg_rd_addr_a_i,
    input  logic [RegAddrWidth-1:0]       reg_rd_addr_b_i,
    input  logic [RegAddrWidth-1:0]       reg_wr_addr_i,
    input  logic                          reg_wr_en_i,
    input  logic [SrcWidth-1:0]           reg_src_i,
    input  logic                          qhv_wen_i,
    input  logic                          qhv_clr_i,
    input  logic [SrcWidth-1:0]           qhv_src_i,
    output logic [HVDimension-1:0]        qhv_o,
    output logic                          qhv_valid_o,
    input  logic                          qhv_ready_i,
    output logic [15:0]                   qhv_count_o
);

    localparam int SrcBusW = NumSrc * HVDimension;

    logic                   fire;
    logic [SrcBusW-1:0]     src_base;
    logic [SrcBusW-1:0]     src_all;
    logic [HVDimension-1:0] reg_rd_a, reg_rd_b, reg_wr_data;
    logic [HVDimension-1:0] alu_a, alu_b, alu_res, qhv_sel;
    logic [31:0]            rot_amt;

    logic [HVDimension-1:0] qhv_q, qhv_d;
    logic                   qhv_valid_q, qhv_valid_d;
    logic [15:0]            qhv_count_q, qhv_count_d;

    assign instr_ready_o = !qhv_valid_q || qhv_ready_i;
    assign fire          = instr_valid_i && instr_ready_o;

    // src_base has the ALU slot zeroed; it feeds the ALU operands so no loop forms.
    assign src_base[SRC_IM_A*HVDimension  +: HVDimension] = im_rd_a_i;
    assign src_base[SRC_IM_B*HVDimension  +: HVDimension] = im_rd_b_i;
    assign src_base[SRC_REG_A*HVDimension +: HVDimension] = reg_rd_a;
    assign src_base[SRC_REG_B*HVDimension +: HVDimension] = reg_rd_b;
    assign src_base[SRC_ALU*HVDimension   +: HVDimension] = '0;
    assign src_all = src_base | ({{(SrcBusW-HVDimension){1'b0}}, alu_res} << (SRC_ALU*HVDimension));

    hv_enc_src_mux #(.NUM_SRC(NumSrc), .WIDTH(HVDimension), .SEL_W(SrcWidth)) u_mux_alu_a (
        .srcs_i(src_base), .sel_i(alu_src_a_i), .data_o(alu_a)
    );
    hv_enc_src_mux #(.NUM_SRC(NumSrc), .WIDTH(HVDimension), .SEL_W(SrcWidth)) u_mux_alu_b (
        .srcs_i(src_base), .sel_i(alu_src_b_i), .data_o(alu_b)
    );
    hv_enc_src_mux #(.NUM_SRC(NumSrc), .WIDTH(HVDimension), .SEL_W(SrcWidth)) u_mux_reg (
        .srcs_i(src_all), .sel_i(reg_src_i), .data_o(reg_wr_data)
    );
    hv_enc_src_mux #(.NUM_SRC(NumSrc), .WIDTH(HVDimension), .SEL_W(SrcWidth)) u_mux_qhv (
        .srcs_i(src_all), .sel_i(qhv_src_i), .data_o(qhv_sel)
    );

    // Permute is a left rotation; shift amounts wrap modulo the HV width.
    assign rot_amt = 32'(alu_shift_amt_i) % 32'(HVDimension);

    always_comb begin
        alu_res = '0;
        case (alu_op_i)
            ALUOpsWidth'(ALU_XOR): alu_res = alu_a ^ alu_b;
            ALUOpsWidth'(ALU_AND): alu_res = alu_a & alu_b;
            ALUOpsWidth'(ALU_OR):  alu_res = alu_a | alu_b;
            ALUOpsWidth'(ALU_ROT): alu_res = (alu_a << rot_amt) | (alu_a >> (32'(HVDimension) - rot_amt));
            default:               alu_res = '0;
        endcase
    end

    reg_file_1w2r #(.WIDTH(HVDimension), .NUM_REGS(RegNum)) u_regs (
        .clk_i       (clk_i),
        .rst_ni      (1'b1),
        .clr_i       (rst_i),
        .wr_en_i     (fire && reg_wr_en_i),
        .wr_addr_i   (reg_wr_addr_i),
        .wr_data_i   (reg_wr_data),
        .rd_addr_a_i (reg_rd_addr_a_i),
        .rd_addr_b_i (reg_rd_addr_b_i),
        .rd_data_a_o (reg_rd_a),
        .rd_data_b_o (reg_rd_b)
    );

    for (genvar k = 0; k < NumBundlers; k++) begin : g_bund
        logic [HVDimension-1:0] bund_in, bund_out;

        hv_enc_src_mux #(.NUM_SRC(NumSrc), .WIDTH(HVDimension), .SEL_W(SrcWidth)) u_mux (
            .srcs_i(src_all), .sel_i(bund_src_i[k*SrcWidth +: SrcWidth]), .data_o(bund_in)
        );

        bundler_set #(.WIDTH(HVDimension), .CNT_W(BundCountWidth)) u_bund (
            .clk_i  (clk_i),
            .rst_ni (1'b1),
            .clr_i  (rst_i || (fire && bund_clr_i[k])),
            .en_i   (fire && bund_valid_i[k]),
            .hv_i   (bund_in),
            .hv_o   (bund_out)
        );

        assign src_base[(SRC_BUND0+k)*HVDimension +: HVDimension] = bund_out;
    end

    always_comb begin
        qhv_d       = qhv_q;
        qhv_valid_d = qhv_valid_q;
        qhv_count_d = qhv_count_q;
        if (fire && qhv_clr_i) begin
            qhv_d       = '0;
            qhv_valid_d = 1'b0;
        end else if (fire && qhv_wen_i) begin
            qhv_d       = qhv_sel;
            qhv_valid_d = 1'b1;
            qhv_count_d = qhv_count_q + 16'd1;
        end else if (qhv_valid_q && qhv_ready_i) begin
            qhv_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            qhv_q       <= '0;
            qhv_valid_q <= 1'b0;
            qhv_count_q <= '0;
        end else begin
            qhv_q       <= qhv_d;
            qhv_valid_q <= qhv_valid_d;
            qhv_count_q <= qhv_count_d;
        end
    end

    assign qhv_o       = qhv_q;
    assign qhv_valid_o = qhv_valid_q;
    assign qhv_count_o = qhv_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hv_encoder_mc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hv_encoder_mc : directed stimulus, bench-side behavioural model, literals
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_hv_encoder_mc;

    localparam int HV  = 64;
    localparam int NB  = 2;
    localparam int BCW = 8;
    localparam int RN  = 8;
    localparam int SW  = 3;
    localparam int AW  = 3;
    localparam int OW  = 2;
    localparam int SHW = 7;
    localparam logic [HV-1:0] ONES = {HV{1'b1}};

    logic          clk = 1'b0;
    logic          rst;
    logic [HV-1:0] im_a, im_b;
    logic          instr_valid;
    wire           instr_ready;
    logic [SW-1:0] alu_src_a, alu_src_b;
    logic [OW-1:0] alu_op;
    logic [SHW-1:0] shamt;
    logic [NB*SW-1:0] bund_src;
    logic [NB-1:0] bund_valid, bund_clr;
    logic [AW-1:0] rd_a, rd_b, wr_addr;
    logic          reg_wr_en;
    logic [SW-1:0] reg_src;
    logic          qhv_wen, qhv_clr;
    logic [SW-1:0] qhv_src;
    wire [HV-1:0]  qhv_o;
    wire           qhv_valid;
    logic          qhv_ready;
    wire [15:0]    qhv_count;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 0;

    always #5 clk = ~clk;

    hv_encoder_mc #(
        .HVDimension(HV), .NumBundlers(NB), .BundCountWidth(BCW),
        .RegNum(RN), .NumALUOps(4), .ALUMaxShiftAmt(128)
    ) dut (
        .clk_i(clk), .rst_i(rst), .im_rd_a_i(im_a), .im_rd_b_i(im_b),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .alu_src_a_i(alu_src_a), .alu_src_b_i(alu_src_b), .alu_op_i(alu_op),
        .alu_shift_amt_i(shamt), .bund_src_i(bund_src), .bund_valid_i(bund_valid),
        .bund_clr_i(bund_clr), .reg_rd_addr_a_i(rd_a), .reg_rd_addr_b_i(rd_b),
        .reg_wr_addr_i(wr_addr), .reg_wr_en_i(reg_wr_en), .reg_src_i(reg_src),
        .qhv_wen_i(qhv_wen), .qhv_clr_i(qhv_clr), .qhv_src_i(qhv_src),
        .qhv_o(qhv_o), .qhv_valid_o(qhv_valid), .qhv_ready_i(qhv_ready),
        .qhv_count_o(qhv_count)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Behavioural model: plain integer counters per bit and a register array.
    logic [HV-1:0] m_reg [RN];
    int            m_cnt [NB][HV];
    logic [HV-1:0] m_qhv   = '0;
    bit            m_valid = 0;
    int            m_count = 0;

    function automatic logic [HV-1:0] m_bund(input int k);
        logic [HV-1:0] r;
        for (int i = 0; i < HV; i++) r[i] = (m_cnt[k][i] > 0);
        return r;
    endfunction

    function automatic logic [HV-1:0] m_src(input int code, input logic [HV-1:0] alu_v);
        if (code == 0) return im_a;
        if (code == 1) return im_b;
        if (code == 2) return m_reg[rd_a];
        if (code == 3) return m_reg[rd_b];
        if (code == 4) return alu_v;
        if (code >= 5 && code < 5 + NB) return m_bund(code - 5);
        return '0;
    endfunction

    function automatic logic [HV-1:0] m_alu(input logic [HV-1:0] a, input logic [HV-1:0] b);
        logic [HV-1:0] r;
        int s;
        s = int'(shamt) % HV;
        r = '0;
        case (int'(alu_op))
            0: r = a ^ b;
            1: r = a & b;
            2: r = a | b;
            default: for (int i = 0; i < HV; i++) r[(i + s) % HV] = a[i];
        endcase
        return r;
    endfunction

    initial begin : model
        logic [HV-1:0] a_v, b_v, alu_v, wd, qd;
        logic [HV-1:0] bin [NB];
        bit fire;
        int v;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int r = 0; r < RN; r++) m_reg[r] = '0;
                for (int k = 0; k < NB; k++)
                    for (int i = 0; i < HV; i++) m_cnt[k][i] = 0;
                m_qhv = '0; m_valid = 0; m_count = 0;
            end else begin
                fire  = instr_valid && (!m_valid || qhv_ready);
                a_v   = m_src(int'(alu_src_a), '0);
                b_v   = m_src(int'(alu_src_b), '0);
                alu_v = m_alu(a_v, b_v);
                for (int k = 0; k < NB; k++) bin[k] = m_src(int'(bund_src[k*SW +: SW]), alu_v);
                wd = m_src(int'(reg_src), alu_v);
                qd = m_src(int'(qhv_src), alu_v);
                if (fire) begin
                    for (int k = 0; k < NB; k++) begin
                        if (bund_clr[k]) begin
                            for (int i = 0; i < HV; i++) m_cnt[k][i] = 0;
                        end else if (bund_valid[k]) begin
                            for (int i = 0; i < HV; i++) begin
                                v = m_cnt[k][i] + (bin[k][i] ? 1 : -1);
                                if (v > 2**(BCW-1) - 1) v = 2**(BCW-1) - 1;
                                if (v < -(2**(BCW-1))) v = -(2**(BCW-1));
                                m_cnt[k][i] = v;
                            end
                        end
                    end
                    if (reg_wr_en) m_reg[wr_addr] = wd;
                end
                if (fire && qhv_clr) begin
                    m_qhv = '0; m_valid = 0;
                end else if (fire && qhv_wen) begin
                    m_qhv = qd; m_valid = 1; m_count = (m_count + 1) % 65536;
                end else if (m_valid && qhv_ready) begin
                    m_valid = 0;
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("model_qhv",   64'(qhv_o),       64'(m_qhv));
                check("model_valid", 64'(qhv_valid),   64'(m_valid));
                check("model_count", 64'(qhv_count),   64'(m_count));
                check("model_ready", 64'(instr_ready), 64'(!m_valid || qhv_ready));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ctl();
        instr_valid = 0; alu_src_a = '0; alu_src_b = '0; alu_op = '0; shamt = '0;
        bund_src = '0; bund_valid = '0; bund_clr = '0; rd_a = '0; rd_b = '0;
        wr_addr = '0; reg_wr_en = 0; reg_src = '0; qhv_wen = 0; qhv_clr = 0; qhv_src = '0;
    endtask

    initial begin : stim
        rst = 1; im_a = '0; im_b = '0; qhv_ready = 1;
        clr_ctl();
        step();
        chk_en = 1;
        step();
        rst = 0;
        step();
        check("rst_qhv",   64'(qhv_o), 64'h0);
        check("rst_valid", 64'(qhv_valid), 64'h0);
        check("rst_count", 64'(qhv_count), 64'h0);
        check("rst_ready", 64'(instr_ready), 64'h1);

        // Back-pressure: first write lands, second stalls until drained.
        instr_valid = 1; im_a = 64'hA5A5_A5A5_A5A5_A5A5; qhv_src = 3'd0; qhv_wen = 1; qhv_ready = 0;
        step();
        check("bp_qhv",   64'(qhv_o), 64'hA5A5_A5A5_A5A5_A5A5);
        check("bp_valid", 64'(qhv_valid), 64'h1);
        check("bp_ready", 64'(instr_ready), 64'h0);
        im_b = 64'h3C3C_3C3C_3C3C_3C3C; qhv_src = 3'd1;
        repeat (3) step();
        check("stall_qhv",   64'(qhv_o), 64'hA5A5_A5A5_A5A5_A5A5);
        check("stall_count", 64'(qhv_count), 64'd1);
        qhv_ready = 1;
        step();
        check("unstall_qhv",   64'(qhv_o), 64'h3C3C_3C3C_3C3C_3C3C);
        check("unstall_count", 64'(qhv_count), 64'd2);
        clr_ctl();
        step();
        check("drain_valid", 64'(qhv_valid), 64'h0);
        check("drain_hold",  64'(qhv_o), 64'h3C3C_3C3C_3C3C_3C3C);

        // Bundler 1 majority over ones, ones, zeros.
        instr_valid = 1; bund_src = 6'b000_000; bund_valid = 2'b10;
        im_a = ONES; step(); step();
        im_a = '0;   step();
        bund_valid = 2'b00; qhv_src = 3'd6; qhv_wen = 1;
        step();
        check("bund_major", 64'(qhv_o), ONES);
        qhv_wen = 0; bund_valid = 2'b10; im_a = '0;
        repeat (3) step();
        bund_clr = 2'b10; im_a = ONES;
        step();
        bund_clr = 2'b00; bund_valid = 2'b00; qhv_wen = 1;
        step();
        check("bund_clr_zero", 64'(qhv_o), 64'h0);
        qhv_wen = 0; bund_valid = 2'b10; im_a = ONES;
        step();
        bund_valid = 2'b00; qhv_wen = 1;
        step();
        check("bund_after_clr", 64'(qhv_o), ONES);
        qhv_wen = 0; bund_src = 6'b000_110; bund_valid = 2'b01;
        step();
        bund_valid = 2'b00; qhv_src = 3'd5; qhv_wen = 1;
        step();
        check("bund_cross_fb", 64'(qhv_o), ONES);
        check("bund_count",    64'(qhv_count), 64'd6);

        // ALU XOR into reg 5, then read-back and read-during-write.
        clr_ctl(); instr_valid = 1;
        im_a = 64'h0123_4567_89AB_CDEF; im_b = 64'h0F0F_0F0F_0F0F_0F0F;
        alu_src_a = 3'd0; alu_src_b = 3'd1; alu_op = 2'd0;
        reg_wr_en = 1; wr_addr = 3'd5; reg_src = 3'd4;
        step();
        clr_ctl(); instr_valid = 1; rd_a = 3'd5; qhv_src = 3'd2; qhv_wen = 1;
        step();
        check("reg_xor", 64'(qhv_o), 64'h0E2C_4A68_86A4_C2E0);
        im_a = 64'hDEAD_BEEF_CAFE_F00D; reg_wr_en = 1; wr_addr = 3'd5; reg_src = 3'd0;
        step();
        check("reg_rdw_old", 64'(qhv_o), 64'h0E2C_4A68_86A4_C2E0);
        reg_wr_en = 0; rd_b = 3'd5; qhv_src = 3'd3;
        step();
        check("reg_new", 64'(qhv_o), 64'hDEAD_BEEF_CAFE_F00D);

        // Out-of-range source and ALU-on-ALU operand.
        clr_ctl(); instr_valid = 1; qhv_src = 3'd7; qhv_wen = 1;
        step();
        check("oor_qhv",   64'(qhv_o), 64'h0);
        check("oor_valid", 64'(qhv_valid), 64'h1);
        alu_src_a = 3'd4; alu_src_b = 3'd1; im_b = 64'h1122_3344_5566_7788; alu_op = 2'd2; qhv_src = 3'd4;
        step();
        check("alu_self_zero", 64'(qhv_o), 64'h1122_3344_5566_7788);
        alu_src_a = 3'd0; im_a = 64'h1; alu_op = 2'd3; shamt = 7'd4;
        step();
        check("rot4", 64'(qhv_o), 64'h10);
        shamt = 7'd67;
        step();
        check("rot67", 64'(qhv_o), 64'h8);
        im_a = 64'h8000_0000_0000_0001; shamt = 7'd1;
        step();
        check("rot_wrap", 64'(qhv_o), 64'h3);
        alu_src_b = 3'd1; alu_op = 2'd1; im_a = 64'hF0F0_F0F0_F0F0_F0F0; im_b = 64'hFF00_FF00_FF00_FF00;
        step();
        check("alu_and", 64'(qhv_o), 64'hF000_F000_F000_F000);
        check("alu_count", 64'(qhv_count), 64'd15);

        // Clear beats write; count held.
        clr_ctl(); instr_valid = 1; qhv_clr = 1; qhv_wen = 1; qhv_src = 3'd0; im_a = ONES;
        step();
        check("clrwen_qhv",   64'(qhv_o), 64'h0);
        check("clrwen_valid", 64'(qhv_valid), 64'h0);
        check("clrwen_count", 64'(qhv_count), 64'd15);

        // Counter wrap at 65536 writes.
        qhv_clr = 0;
        for (int n = 0; n < 65536 - 15; n++) begin
            im_a = {$urandom, $urandom};
            step();
        end
        check("count_wrap", 64'(qhv_count), 64'd0);

        // Reset with a pending qhv discards it.
        qhv_ready = 0;
        step();
        check("pend_valid", 64'(qhv_valid), 64'h1);
        rst = 1; instr_valid = 0;
        step();
        rst = 0;
        check("mrst_valid", 64'(qhv_valid), 64'h0);
        check("mrst_count", 64'(qhv_count), 64'h0);
        check("mrst_qhv",   64'(qhv_o), 64'h0);
        check("mrst_ready", 64'(instr_ready), 64'h1);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
